// File: rtl/line_memory.sv
//------------------------------------------------------------------------------
// Module      : line_memory
// Description : Off-chip line memory model answering 256-bit line fills and
//               write-backs after a fixed countdown latency.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module line_memory #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [255:0] data_i,
    input  logic [31:0]  addr_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    localparam int         c_IDX_W = $clog2(DEPTH);
    localparam logic [7:0] c_LOAD  = 8'(LATENCY - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;
    // A single-cycle latency skips the countdown entirely.
    localparam logic [1:0] c_ST_AFTER_ACCEPT = (LATENCY > 1) ? c_ST_BUSY : c_ST_ACK;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [7:0]         r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_we;
    logic [255:0]       r_wdata;
    logic [255:0]       r_rdata;
    logic [255:0]       r_mem [DEPTH];

    logic [c_IDX_W-1:0] w_addr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic               w_rd_we;
    logic               w_enter_ack;
    logic               w_unused_addr;

    assign w_addr_idx    = addr_i[c_IDX_W+4:5];
    assign w_unused_addr = ^{addr_i[31:c_IDX_W+5], addr_i[4:0]};

    // Entering ACK straight from IDLE must use the request being accepted now.
    assign w_rd_idx    = (r_state == c_ST_IDLE) ? w_addr_idx : r_idx;
    assign w_rd_we     = (r_state == c_ST_IDLE) ? write_i    : r_we;
    assign w_enter_ack = (w_state_next == c_ST_ACK) && (r_state != c_ST_ACK);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (enable_i) w_state_next = c_ST_AFTER_ACCEPT;
            c_ST_BUSY: if (r_cnt == 8'd1) w_state_next = c_ST_ACK;
            c_ST_ACK:  w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 8'd0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == c_ST_IDLE && enable_i) begin
                r_idx   <= w_addr_idx;
                r_we    <= write_i;
                r_wdata <= data_i;
                r_cnt   <= c_LOAD;
            end else if (r_state == c_ST_BUSY) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_enter_ack && !w_rd_we) begin
                r_rdata <= r_mem[w_rd_idx];
            end
        end
    end

    // Array has no reset; a reset forces IDLE so an aborted write never lands.
    always_ff @(posedge clk_i) begin
        if (r_state == c_ST_ACK && r_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign ack_o  = (r_state == c_ST_ACK);
    assign data_o = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_line_memory.sv
//------------------------------------------------------------------------------
// Module      : tb_line_memory
// Description : Randomized self-checking bench for line_memory against a
//               line-array reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_line_memory;

    localparam int LAT_A = 10;
    localparam int DEPTH = 512;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic [255:0] a_data = '0;
    logic [31:0]  a_addr = '0;
    logic         a_en   = 1'b0;
    logic         a_wr   = 1'b0;
    logic         a_ack;
    logic [255:0] a_q;

    logic [255:0] b_data = '0;
    logic [31:0]  b_addr = '0;
    logic         b_en   = 1'b0;
    logic         b_wr   = 1'b0;
    logic         b_ack;
    logic [255:0] b_q;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] ref_mem   [DEPTH];
    bit           ref_valid [DEPTH];
    logic [255:0] last_rd = '0;

    line_memory #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .data_i   (a_data),
        .addr_i   (a_addr),
        .enable_i (a_en),
        .write_i  (a_wr),
        .ack_o    (a_ack),
        .data_o   (a_q)
    );

    line_memory #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
        .clk_i    (clk),
        .rst_i    (rst),
        .data_i   (b_data),
        .addr_i   (b_addr),
        .enable_i (b_en),
        .write_i  (b_wr),
        .ack_o    (b_ack),
        .data_o   (b_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr / 32) % DEPTH);
    endfunction

    // One request on the LATENCY=10 instance; inputs are scrambled while busy.
    task automatic do_txn(input logic [31:0] addr, input bit wr,
                          input logic [255:0] wdata, input bit churn);
        int k;
        int idx;
        idx = line_of(addr);
        @(negedge clk);
        a_addr = addr; a_wr = wr; a_data = wdata; a_en = 1'b1;
        @(posedge clk); #1;
        if (!churn) begin
            a_en = 1'b0; a_addr = $urandom; a_data = rand_line(); a_wr = 1'($urandom);
        end
        k = 0;
        while (!a_ack && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (churn && k == 2) begin
                a_en = 1'b0; a_addr = 32'h80; a_wr = 1'b1; a_data = rand_line();
            end
        end
        check("ack_seen", 256'(a_ack), 256'(1));
        check("latency", 256'(k), 256'(LAT_A - 1));
        if (!wr) begin
            if (ref_valid[idx]) begin
                check("rd_data", a_q, ref_mem[idx]);
                last_rd = ref_mem[idx];
            end else begin
                last_rd = a_q;
            end
        end
        @(posedge clk); #1;
        a_en = 1'b0;
        check("ack_one_cycle", 256'(a_ack), 256'(0));
        check("q_hold", a_q, last_rd);
        if (wr) begin
            ref_mem[idx]   = wdata;
            ref_valid[idx] = 1'b1;
        end
    endtask

    initial begin
        logic [31:0]  pool [8];
        logic [255:0] line_a;
        logic [255:0] w;
        int           seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 256'(a_ack), 256'(0));
        check("rst_q", a_q, 256'(0));
        @(negedge clk) rst = 1'b0;

        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (a_ack || a_q != '0 || b_ack) seen++;
        end
        check("idle_quiet", 256'(seen), 256'(0));

        do_txn(32'h0000_0440, 1'b1, {8{32'hDEAD_BEEF}}, 1'b0);
        do_txn(32'h0000_0440, 1'b0, '0, 1'b0);
        check("deadbeef", a_q, {8{32'hDEAD_BEEF}});

        line_a = rand_line();
        do_txn(32'h0000_0020, 1'b1, line_a, 1'b0);
        do_txn(32'h0000_4025, 1'b0, '0, 1'b0);
        check("wrap_line_a", a_q, line_a);

        do_txn(32'h0000_0040, 1'b1, rand_line(), 1'b0);
        do_txn(32'h0000_0080, 1'b1, rand_line(), 1'b0);
        do_txn(32'h0000_0040, 1'b0, '0, 1'b1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (a_ack) seen++;
        end
        check("no_second_ack", 256'(seen), 256'(0));

        for (int i = 0; i < 8; i++) begin
            pool[i] = ($urandom & 32'hFFFF_FFE0) | 32'($urandom_range(0, 31));
            do_txn(pool[i], 1'b1, rand_line(), 1'b0);
        end
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ad;
            ad = pool[$urandom_range(0, 7)] ^ {($urandom & 32'hFFFF_C000), 9'd0 , 5'($urandom)} ;
            ad = (pool[$urandom_range(0, 7)] & 32'h0000_3FE0) | ($urandom & 32'hFFFF_C01F);
            do_txn(ad, 1'($urandom), rand_line(), 1'b0);
        end

        w = rand_line();
        do_txn(32'h0000_0100, 1'b1, w, 1'b0);
        @(negedge clk);
        a_addr = 32'h0000_0100; a_wr = 1'b1; a_data = rand_line(); a_en = 1'b1;
        @(posedge clk); #1;
        a_en = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_ack", 256'(a_ack), 256'(0));
        check("async_rst_q", a_q, 256'(0));
        last_rd = '0;
        @(negedge clk) rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (a_ack) seen++;
        end
        check("aborted_no_ack", 256'(seen), 256'(0));
        do_txn(32'h0000_0100, 1'b0, '0, 1'b0);
        check("aborted_not_written", a_q, w);

        @(negedge clk);
        b_addr = 32'h0000_0660; b_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w = rand_line();
            b_wr = 1'b1; b_data = w;
            @(posedge clk); #1;
            check("b_wr_ack", 256'(b_ack), 256'(1));
            @(posedge clk); #1;
            check("b_gap1", 256'(b_ack), 256'(0));
            b_wr = 1'b0; b_data = rand_line();
            @(posedge clk); #1;
            check("b_rd_ack", 256'(b_ack), 256'(1));
            check("b_rd_data", b_q, w);
            @(posedge clk); #1;
            check("b_gap2", 256'(b_ack), 256'(0));
        end
        b_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
